// File: rtl/game_sprite_unit.sv
// Per-object sprite stage: holds and advances position once per frame, detects
// when the object leaves the screen, and renders its 8x8 mask with a 2-cycle latency.
module game_sprite_unit #(
  parameter int                        SCREEN_W    = 640,
  parameter int                        SCREEN_H    = 480,
  parameter int                        POS_W       = 11,
  parameter int                        D_W         = 4,
  parameter logic signed [POS_W-1:0]   START_X     = '0,
  parameter logic signed [POS_W-1:0]   START_Y     = '0,
  parameter int                        RGB_W       = 3,
  parameter logic [RGB_W-1:0]          SPRITE_RGB  = 3'b010,
  parameter logic [63:0]               SPRITE_MASK = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [9:0]              pixel_x,
  input  logic [9:0]              pixel_y,
  input  logic                    display_on,
  input  logic                    frame_tick,
  input  logic                    start,
  input  logic                    kill,
  input  logic signed [D_W-1:0]   dx,
  input  logic signed [D_W-1:0]   dy,
  output logic signed [POS_W-1:0] sprite_x,
  output logic signed [POS_W-1:0] sprite_y,
  output logic                    active,
  output logic                    exited,
  output logic                    rgb_en,
  output logic [RGB_W-1:0]        rgb
);

  typedef enum logic [1:0] {IDLE, ACTIVE, EXITED} state_t;

  localparam logic signed [POS_W:0] NEG8  = (POS_W+1)'(-8);
  localparam logic signed [POS_W:0] LIM_W = (POS_W+1)'(SCREEN_W);
  localparam logic signed [POS_W:0] LIM_H = (POS_W+1)'(SCREEN_H);

  state_t                  state, state_n;
  logic signed [POS_W-1:0] x_n, y_n, next_x, next_y;
  logic signed [D_W-1:0]   dx_l, dy_l, dx_n, dy_n;
  logic signed [POS_W:0]   nx_e, ny_e;
  logic                    off_screen, exited_n;

  logic signed [POS_W:0]   px_e, py_e, sx_e, sy_e, diff_x, diff_y;
  logic                    hit_n, hit_q;
  logic [2:0]              col_q, row_q;
  logic                    mask_bit;

  assign next_x = sprite_x + POS_W'(dx_l);
  assign next_y = sprite_y + POS_W'(dy_l);
  assign nx_e   = {next_x[POS_W-1], next_x};
  assign ny_e   = {next_y[POS_W-1], next_y};
  assign off_screen = (nx_e <= NEG8) || (nx_e >= LIM_W) ||
                      (ny_e <= NEG8) || (ny_e >= LIM_H);

  // kill outranks start, and start outranks the per-frame move
  always_comb begin
    state_n  = state;
    x_n      = sprite_x;
    y_n      = sprite_y;
    dx_n     = dx_l;
    dy_n     = dy_l;
    exited_n = 1'b0;
    if (kill) begin
      state_n = IDLE;
    end else if (start) begin
      state_n = ACTIVE;
      x_n     = START_X;
      y_n     = START_Y;
      dx_n    = dx;
      dy_n    = dy;
    end else if (state == ACTIVE && frame_tick) begin
      x_n = next_x;
      y_n = next_y;
      if (off_screen) begin
        state_n  = EXITED;
        exited_n = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      sprite_x <= START_X;
      sprite_y <= START_Y;
      dx_l     <= '0;
      dy_l     <= '0;
      exited   <= 1'b0;
    end else begin
      state    <= state_n;
      sprite_x <= x_n;
      sprite_y <= y_n;
      dx_l     <= dx_n;
      dy_l     <= dy_n;
      exited   <= exited_n;
    end
  end

  assign active = (state == ACTIVE);

  // Offsets in one extra signed bit so off-screen-left/top positions compare correctly
  assign px_e   = $signed({{(POS_W+1-10){1'b0}}, pixel_x});
  assign py_e   = $signed({{(POS_W+1-10){1'b0}}, pixel_y});
  assign sx_e   = {sprite_x[POS_W-1], sprite_x};
  assign sy_e   = {sprite_y[POS_W-1], sprite_y};
  assign diff_x = px_e - sx_e;
  assign diff_y = py_e - sy_e;
  assign hit_n  = display_on && active &&
                  (diff_x[POS_W:3] == '0) && (diff_y[POS_W:3] == '0);
  assign mask_bit = SPRITE_MASK[{row_q, col_q}];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_q  <= 1'b0;
      col_q  <= '0;
      row_q  <= '0;
      rgb_en <= 1'b0;
      rgb    <= '0;
    end else begin
      hit_q  <= hit_n;
      col_q  <= diff_x[2:0];
      row_q  <= diff_y[2:0];
      rgb_en <= hit_q & mask_bit;
      rgb    <= (hit_q & mask_bit) ? SPRITE_RGB : '0;
    end
  end

endmodule

// File: tb/tb_game_sprite_unit.sv
// Directed bench for game_sprite_unit: three instances (full mask at 100,50;
// single-pixel mask at 10,10; right-edge start at 630,0) sharing raster inputs.
module tb_game_sprite_unit;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [9:0]        pixel_x = '0, pixel_y = '0;
  logic              display_on = 1'b0, frame_tick = 1'b0;
  logic              start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
  logic              kill_a = 1'b0, kill_b = 1'b0, kill_c = 1'b0;
  logic signed [3:0] dx = '0, dy = '0;

  logic signed [10:0] x_a, y_a, x_b, y_b, x_c, y_c;
  logic               act_a, act_b, act_c, ex_a, ex_b, ex_c;
  logic               en_a, en_b, en_c;
  logic [2:0]         rgb_a, rgb_b, rgb_c;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  game_sprite_unit #(.START_X(11'sd100), .START_Y(11'sd50)) u_a (
    .clk(clk), .rst(rst), .pixel_x(pixel_x), .pixel_y(pixel_y), .display_on(display_on),
    .frame_tick(frame_tick), .start(start_a), .kill(kill_a), .dx(dx), .dy(dy),
    .sprite_x(x_a), .sprite_y(y_a), .active(act_a), .exited(ex_a), .rgb_en(en_a), .rgb(rgb_a));

  game_sprite_unit #(.START_X(11'sd10), .START_Y(11'sd10), .SPRITE_MASK(64'h1)) u_b (
    .clk(clk), .rst(rst), .pixel_x(pixel_x), .pixel_y(pixel_y), .display_on(display_on),
    .frame_tick(frame_tick), .start(start_b), .kill(kill_b), .dx(dx), .dy(dy),
    .sprite_x(x_b), .sprite_y(y_b), .active(act_b), .exited(ex_b), .rgb_en(en_b), .rgb(rgb_b));

  game_sprite_unit #(.START_X(11'sd630), .START_Y(11'sd0)) u_c (
    .clk(clk), .rst(rst), .pixel_x(pixel_x), .pixel_y(pixel_y), .display_on(display_on),
    .frame_tick(frame_tick), .start(start_c), .kill(kill_c), .dx(dx), .dy(dy),
    .sprite_x(x_c), .sprite_y(y_c), .active(act_c), .exited(ex_c), .rgb_en(en_c), .rgb(rgb_c));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame_pulse();
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    tick();
  endtask

  task automatic flush();
    display_on = 1'b0;
    tick();
    tick();
  endtask

  task automatic set_pix(input int px, input int py, input logic on);
    pixel_x    = 10'(px);
    pixel_y    = 10'(py);
    display_on = on;
  endtask

  task automatic test_reset();
    #12;
    tests++; if (x_a !== 11'sd100 || y_a !== 11'sd50) begin fails++;
      $display("FAIL reset_pos_a: got %0d,%0d expected 100,50", x_a, y_a); end
    tests++; if (x_c !== 11'sd630) begin fails++;
      $display("FAIL reset_pos_c: got %0d expected 630", x_c); end
    tests++; if ({act_a, ex_a, en_a, rgb_a} !== 6'b0) begin fails++;
      $display("FAIL reset_outs: got act=%b ex=%b en=%b rgb=%b expected all 0", act_a, ex_a, en_a, rgb_a); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_move();
    logic saw_exit = 1'b0;
    frame_pulse();
    tests++; if (x_c !== 11'sd630 || act_c !== 1'b0) begin fails++;
      $display("FAIL idle_hold: got x=%0d act=%b expected 630,0", x_c, act_c); end
    dx = 4'sd2; dy = -4'sd1;
    start_a = 1'b1; tick(); start_a = 1'b0;
    tests++; if (act_a !== 1'b1 || x_a !== 11'sd100 || y_a !== 11'sd50) begin fails++;
      $display("FAIL start_load: got act=%b pos=%0d,%0d expected 1,100,50", act_a, x_a, y_a); end
    for (int f = 0; f < 3; f++) begin
      frame_tick = 1'b1; tick(); frame_tick = 1'b0;
      saw_exit |= ex_a;
      for (int k = 0; k < 3; k++) begin tick(); saw_exit |= ex_a; end
    end
    tests++; if (x_a !== 11'sd106 || y_a !== 11'sd47 || act_a !== 1'b1) begin fails++;
      $display("FAIL move3: got pos=%0d,%0d act=%b expected 106,47,1", x_a, y_a, act_a); end
    tests++; if (saw_exit !== 1'b0) begin fails++;
      $display("FAIL move_no_exit: got exited seen=%b expected 0", saw_exit); end
  endtask

  task automatic test_render();
    int  px[6]  = '{100, 99, 108, 100, 100, 107};
    int  py[6]  = '{50, 50, 50, 58, 50, 57};
    logic on[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic ex[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    dx = '0; dy = '0;
    start_a = 1'b1; tick(); start_a = 1'b0;
    set_pix(100, 50, 1'b1);
    tick();
    tests++; if (en_a !== 1'b0) begin fails++;
      $display("FAIL latency_n1: got rgb_en=%b expected 0 one cycle after pixel", en_a); end
    tick();
    tests++; if (en_a !== 1'b1 || rgb_a !== 3'b010) begin fails++;
      $display("FAIL latency_n2: got en=%b rgb=%b expected 1,010", en_a, rgb_a); end
    flush();
    for (int i = 0; i < 6; i++) begin
      set_pix(px[i], py[i], on[i]);
      tick(); tick();
      tests++; if (en_a !== ex[i] || rgb_a !== (ex[i] ? 3'b010 : 3'b000)) begin fails++;
        $display("FAIL render_%0d_%0d_on%0b: got en=%b rgb=%b expected en=%b", px[i], py[i], on[i], en_a, rgb_a, ex[i]); end
      flush();
    end
  endtask

  task automatic test_mask();
    int   px[4] = '{10, 11, 10, 17};
    int   py[4] = '{10, 10, 11, 17};
    logic ex[4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    dx = '0; dy = '0;
    start_b = 1'b1; tick(); start_b = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_pix(px[i], py[i], 1'b1);
      tick(); tick();
      tests++; if (en_b !== ex[i] || rgb_b !== (ex[i] ? 3'b010 : 3'b000)) begin fails++;
        $display("FAIL mask1_%0d_%0d: got en=%b rgb=%b expected en=%b", px[i], py[i], en_b, rgb_b, ex[i]); end
      flush();
    end
  endtask

  task automatic test_offscreen_left();
    int   px[4] = '{0, 2, 3, 639};
    logic ex[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    dx = -4'sd7; dy = '0;
    start_a = 1'b1; tick(); start_a = 1'b0;
    for (int f = 0; f < 15; f++) frame_pulse();
    tests++; if (x_a !== -11'sd5 || act_a !== 1'b1) begin fails++;
      $display("FAIL left_pos: got x=%0d act=%b expected -5,1", x_a, act_a); end
    for (int i = 0; i < 4; i++) begin
      set_pix(px[i], 50, 1'b1);
      tick(); tick();
      tests++; if (en_a !== ex[i]) begin fails++;
        $display("FAIL left_render_%0d: got en=%b expected %b", px[i], en_a, ex[i]); end
      flush();
    end
    frame_tick = 1'b1; tick(); frame_tick = 1'b0;
    tests++; if (x_a !== -11'sd12 || act_a !== 1'b0 || ex_a !== 1'b1) begin fails++;
      $display("FAIL left_exit: got x=%0d act=%b ex=%b expected -12,0,1", x_a, act_a, ex_a); end
    tick();
  endtask

  task automatic test_exit();
    logic saw_en = 1'b0;
    dx = 4'sd5; dy = '0;
    start_c = 1'b1; tick(); start_c = 1'b0;
    frame_tick = 1'b1; tick(); frame_tick = 1'b0;
    tests++; if (x_c !== 11'sd635 || act_c !== 1'b1 || ex_c !== 1'b0) begin fails++;
      $display("FAIL exit_f1: got x=%0d act=%b ex=%b expected 635,1,0", x_c, act_c, ex_c); end
    tick();
    set_pix(639, 0, 1'b1);
    tick(); tick();
    tests++; if (en_c !== 1'b1) begin fails++;
      $display("FAIL edge_render: got en=%b expected 1 at pixel 639,0", en_c); end
    flush();
    frame_tick = 1'b1; tick(); frame_tick = 1'b0;
    tests++; if (x_c !== 11'sd640 || act_c !== 1'b0 || ex_c !== 1'b1) begin fails++;
      $display("FAIL exit_f2: got x=%0d act=%b ex=%b expected 640,0,1", x_c, act_c, ex_c); end
    tick();
    tests++; if (ex_c !== 1'b0) begin fails++;
      $display("FAIL exit_pulse_width: got ex=%b expected 0 on second cycle", ex_c); end
    for (int y = 0; y < 8; y++)
      for (int x = 632; x < 640; x++) begin
        set_pix(x, y, 1'b1);
        tick();
        saw_en |= en_c;
      end
    flush();
    tests++; if (saw_en !== 1'b0) begin fails++;
      $display("FAIL exited_no_render: got rgb_en seen=%b expected 0", saw_en); end
    start_c = 1'b1; tick(); start_c = 1'b0;
    tests++; if (act_c !== 1'b1 || x_c !== 11'sd630) begin fails++;
      $display("FAIL restart_from_exited: got act=%b x=%0d expected 1,630", act_c, x_c); end
  endtask

  task automatic test_priority();
    dx = 4'sd2; dy = 4'sd1;
    start_a = 1'b1; tick(); start_a = 1'b0;
    frame_pulse();
    start_a = 1'b1; frame_tick = 1'b1; tick(); start_a = 1'b0; frame_tick = 1'b0;
    tests++; if (x_a !== 11'sd100 || y_a !== 11'sd50 || act_a !== 1'b1) begin fails++;
      $display("FAIL start_beats_tick: got %0d,%0d act=%b expected 100,50,1", x_a, y_a, act_a); end
    kill_a = 1'b1; start_a = 1'b1; tick(); kill_a = 1'b0; start_a = 1'b0;
    tests++; if (act_a !== 1'b0) begin fails++;
      $display("FAIL kill_beats_start: got act=%b expected 0", act_a); end
  endtask

  task automatic test_async_reset();
    dx = 4'sd2; dy = '0;
    start_a = 1'b1; tick(); start_a = 1'b0;
    frame_pulse();
    set_pix(102, 50, 1'b1);
    tick(); tick();
    tests++; if (en_a !== 1'b1 || x_a !== 11'sd102) begin fails++;
      $display("FAIL pre_reset_render: got en=%b x=%0d expected 1,102", en_a, x_a); end
    #2 rst = 1'b1;
    #1;
    tests++; if (en_a !== 1'b0 || rgb_a !== 3'b000 || act_a !== 1'b0) begin fails++;
      $display("FAIL async_reset_outs: got en=%b rgb=%b act=%b expected 0,000,0", en_a, rgb_a, act_a); end
    tests++; if (x_a !== 11'sd100 || y_a !== 11'sd50) begin fails++;
      $display("FAIL async_reset_pos: got %0d,%0d expected 100,50", x_a, y_a); end
    #3 rst = 1'b0;
    display_on = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_move();
    test_render();
    test_mask();
    test_offscreen_left();
    test_exit();
    test_priority();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
